// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
package sa_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StFlush,
    StDrain,
    StDone
  } sa_state_e;

  localparam int unsigned DEFAULT_N    = 4;
  localparam int unsigned FLUSH_CYCLES = 2 * DEFAULT_N - 1;

  // Full-precision product width plus headroom for K_MAX accumulations.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned k_max);
    return 2 * data_w + $clog2(k_max);
  endfunction

  // Cycles for the last operand to cross the skew lines and the PE grid.
  function automatic int unsigned flush_cycles(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Output-stationary MAC processing element: accumulates a*b and forwards
// its operands right (a) and down (b) through one register each.
module sa_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;

  assign prod = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      a_q <= in_a;
      b_q <= in_b;
      if (clr) begin
        acc_q <= '0;
      end else if (en) begin
        acc_q <= acc_q + ACC_W'(prod);
      end
    end
  end

  assign out_a = a_q;
  assign out_b = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/sa_matmul_engine.sv
// N x N output-stationary systolic matrix multiplier: skewed k-slice input
// stream in, one result row per handshake out.
module sa_matmul_engine
  import sa_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K_MAX  = 64,
  parameter int unsigned ACC_W  = acc_width(DATA_W, K_MAX)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(K_MAX+1)-1:0] k_len,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*DATA_W-1:0]        a_col,
  input  logic [N*DATA_W-1:0]        b_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*ACC_W-1:0]         out_row,
  output logic [$clog2(N)-1:0]       out_row_idx
);

  localparam int unsigned KW      = $clog2(K_MAX + 1);
  localparam int unsigned RW      = $clog2(N);
  localparam int unsigned FLUSH_N = flush_cycles(N);
  localparam int unsigned FW      = $clog2(FLUSH_N + 1);

  localparam logic [KW-1:0] KMaxW     = KW'(K_MAX);
  localparam logic [FW-1:0] FlushLast = FW'(FLUSH_N - 1);
  localparam logic [RW-1:0] RowLast   = RW'(N - 1);

  sa_state_e     state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic [KW-1:0] k_clamped;
  logic          start_acc;
  logic          beat_acc;
  logic          row_acc;
  logic          mac_en;

  assign k_clamped = (k_len > KMaxW) ? KMaxW : k_len;

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    k_len_d   = k_len_q;
    beat_d    = beat_q;
    flush_d   = flush_q;
    row_d     = row_q;
    start_acc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_acc = 1'b1;
          k_len_d   = k_clamped;
          beat_d    = '0;
          flush_d   = '0;
          row_d     = '0;
          state_d   = (k_clamped == '0) ? StDrain : StFeed;
        end
      end
      StFeed: begin
        if (beat_acc) begin
          beat_d = beat_q + KW'(1);
          if (beat_q == k_len_q - KW'(1)) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        flush_d = flush_q + FW'(1);
        if (flush_q == FlushLast) begin
          flush_d = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (row_acc) begin
          row_d = row_q + RW'(1);
          if (row_q == RowLast) begin
            row_d   = '0;
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_len_q <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_len_q <= k_len_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign in_ready    = (state_q == StFeed);
  assign out_valid   = (state_q == StDrain);
  assign beat_acc    = in_valid & in_ready;
  assign row_acc     = out_valid & out_ready;
  assign mac_en      = (state_q == StFeed) || (state_q == StFlush);
  assign out_row_idx = row_q;

  // ---------------------------------------------------------------------------
  // Input skew: lane i is delayed i cycles so PE(i,j) pairs A[i][k] with B[k][j]
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] a_in   [N];
  logic [DATA_W-1:0] b_in   [N];
  logic [DATA_W-1:0] a_edge [N];
  logic [DATA_W-1:0] b_edge [N];

  for (genvar i = 0; i < N; i++) begin : g_skew
    // Idle cycles inject zeros, which leave every accumulator unchanged.
    assign a_in[i] = beat_acc ? a_col[i*DATA_W +: DATA_W] : '0;
    assign b_in[i] = beat_acc ? b_row[i*DATA_W +: DATA_W] : '0;

    if (i == 0) begin : g_direct
      assign a_edge[i] = a_in[i];
      assign b_edge[i] = b_in[i];
    end else begin : g_delay
      logic [DATA_W-1:0] a_dly_q [i];
      logic [DATA_W-1:0] b_dly_q [i];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < i; d++) begin
            a_dly_q[d] <= '0;
            b_dly_q[d] <= '0;
          end
        end else begin
          a_dly_q[0] <= a_in[i];
          b_dly_q[0] <= b_in[i];
          for (int d = 1; d < i; d++) begin
            a_dly_q[d] <= a_dly_q[d-1];
            b_dly_q[d] <= b_dly_q[d-1];
          end
        end
      end

      assign a_edge[i] = a_dly_q[i-1];
      assign b_edge[i] = b_dly_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // PE grid
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] a_h      [N][N];
  logic [DATA_W-1:0] b_v      [N][N];
  logic [ACC_W-1:0]  acc_grid [N][N];

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign a_h[i][0] = a_edge[i];
    assign b_v[0][i] = b_edge[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] fwd_a;
      logic [DATA_W-1:0] fwd_b;

      sa_pe #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start_acc),
        .en   (mac_en),
        .in_a (a_h[i][j]),
        .in_b (b_v[i][j]),
        .out_a(fwd_a),
        .out_b(fwd_b),
        .acc  (acc_grid[i][j])
      );

      if (j < N - 1) begin : g_fwd_a
        assign a_h[i][j+1] = fwd_a;
      end else begin : g_end_a
        logic [DATA_W-1:0] unused_a;
        assign unused_a = fwd_a;
      end

      if (i < N - 1) begin : g_fwd_b
        assign b_v[i+1][j] = fwd_b;
      end else begin : g_end_b
        logic [DATA_W-1:0] unused_b;
        assign unused_b = fwd_b;
      end
    end
  end

  // Row mux; accumulators are frozen in DRAIN so the row holds during stalls.
  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < N; j++) begin
        out_row[j*ACC_W +: ACC_W] = acc_grid[row_q][j];
      end
    end
  end

endmodule

// File: tb/tb_sa_matmul_engine.sv
// Self-checking bench: reference matrix product computed in plain arithmetic,
// every valid output row compared against it.
`timescale 1ns/1ps
module tb_sa_matmul_engine;

  localparam int unsigned N      = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned K_MAX  = 64;
  localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(K_MAX);
  localparam int unsigned KW     = $clog2(K_MAX + 1);
  localparam int unsigned RW     = $clog2(N);

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b1;
  logic                start     = 1'b0;
  logic [KW-1:0]       k_len     = '0;
  logic                in_valid  = 1'b0;
  logic                out_ready = 1'b0;
  logic [N*DATA_W-1:0] a_col     = '0;
  logic [N*DATA_W-1:0] b_row     = '0;
  logic                busy;
  logic                done;
  logic                in_ready;
  logic                out_valid;
  logic [N*ACC_W-1:0]  out_row;
  logic [RW-1:0]       out_row_idx;

  sa_matmul_engine #(
    .N     (N),
    .DATA_W(DATA_W),
    .K_MAX (K_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_col      (a_col),
    .b_row      (b_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_row_idx(out_row_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  int unsigned      a_m   [N][K_MAX];
  int unsigned      b_m   [K_MAX][N];
  logic [ACC_W-1:0] exp_c [N][N];

  int   exp_idx  = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   hs_cnt   = 0;
  int   beat_cnt = 0;
  int   ov_at    = 0;
  logic prev_ov  = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every valid row against the reference product.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0;
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_ov) ov_at = busy_cnt;
        check("row_idx", longint'(out_row_idx), exp_idx);
        for (int j = 0; j < N; j++) begin
          check($sformatf("row%0d_lane%0d", exp_idx, j),
                longint'(out_row[j*ACC_W +: ACC_W]), longint'(exp_c[exp_idx % N][j]));
        end
        if (out_ready) begin
          exp_idx++;
          hs_cnt++;
        end
      end
      if (in_valid && in_ready) beat_cnt++;
      if (done) begin
        done_cnt++;
        exp_idx = 0;
      end
      if (busy) busy_cnt++;
      prev_ov = out_valid;
    end
  end

  // mode_valid: 0 = always valid, 1 = toggling, 2 = random.
  task automatic run_mm(input int k_req, input int mode_valid, input bit stall,
                        input bit rnd_ready, input bit restart, input bit abort);
    int keff;
    int b = 0;
    int guard = 0;
    int stall_left = 3;
    int busy0, done0, hs0, beat0;
    bit pulsed = 0;
    bit pulsed2 = 0;
    keff = (k_req > int'(K_MAX)) ? int'(K_MAX) : k_req;

    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < keff; k++) s += longint'(a_m[r][k]) * longint'(b_m[k][j]);
        exp_c[r][j] = ACC_W'(s);
      end
    end

    @(posedge clk); #1;
    busy0 = busy_cnt; done0 = done_cnt; hs0 = hs_cnt; beat0 = beat_cnt;
    start     = 1'b1;
    k_len     = KW'(k_req);
    out_ready = 1'b1;
    in_valid  = (keff == 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", busy, 1);

    while (b < keff && guard < 4000) begin
      case (mode_valid)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2 == 0);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      for (int i = 0; i < N; i++) begin
        a_col[i*DATA_W +: DATA_W] = DATA_W'(a_m[i][b]);
        b_row[i*DATA_W +: DATA_W] = DATA_W'(b_m[b][i]);
      end
      if (restart && b == 1 && !pulsed) begin
        start = 1'b1; k_len = '0; pulsed = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) b++;
      @(posedge clk); #1;
      guard++;
    end
    start    = 1'b0;
    in_valid = (keff == 0);
    if (guard >= 4000) check("feed_timeout", b, keff);

    if (abort) begin
      repeat (3) @(posedge clk);
      #1;
      check("flush_busy", busy, 1);
      check("flush_no_ready", in_ready, 0);
      check("flush_no_valid", out_valid, 0);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_done", done, 0);
      check("abort_out_row", longint'(out_row[ACC_W-1:0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - done0, 0);
      return;
    end

    guard = 0;
    while (done_cnt == done0 && guard < 2000) begin
      if (rnd_ready) begin
        out_ready = ($urandom_range(0, 1) != 0);
      end else if (stall && out_valid && exp_idx == 1 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      if (restart && out_valid && exp_idx == 2 && !pulsed2) begin
        start = 1'b1; k_len = KW'(3); pulsed2 = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;

    check("done_seen", done_cnt - done0, 1);
    check("busy_after_done", busy, 0);
    check("rows_out", hs_cnt - hs0, N);
    check("beats_taken", beat_cnt - beat0, keff);
    if (mode_valid == 0 && !stall && !rnd_ready && keff > 0) begin
      check("latency", ov_at - busy0, keff + 2 * N - 1);
      check("busy_cycles", busy_cnt - busy0, keff + 3 * N);
    end
    repeat (2) @(posedge clk);
    #1;
    check("single_done", done_cnt - done0, 1);
  endtask

  task automatic fill_const(input int unsigned v);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        a_m[i][k] = v;
        b_m[k][i] = v;
      end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        a_m[i][k] = $urandom_range(0, 255);
        b_m[k][i] = $urandom_range(0, 255);
      end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_row", longint'(out_row[ACC_W-1:0]), 0);
    check("rst_out_row_idx", out_row_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Identity A, B[k][j] = 4k+j+1
    for (int i = 0; i < N; i++)
      for (int k = 0; k < K_MAX; k++) begin
        a_m[i][k] = (i == k) ? 1 : 0;
        b_m[k][i] = 4 * k + i + 1;
      end
    run_mm(4, 0, 0, 0, 0, 0);
    check("pin_identity_33", exp_c[3][3], 16);
    check("pin_identity_12", exp_c[1][2], 7);

    fill_const(255);
    run_mm(64, 0, 0, 0, 0, 0);
    check("pin_max", exp_c[2][1], 4161600);

    fill_const(1);
    run_mm(8, 1, 1, 0, 0, 0);
    check("pin_ones", exp_c[0][3], 8);

    fill_random();
    run_mm(6, 0, 0, 0, 1, 0);

    fill_random();
    run_mm(0, 0, 0, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_mm(int'($urandom_range(1, 20)), 2, 0, 1, 0, 0);
    end

    fill_random();
    run_mm(100, 2, 0, 1, 0, 0);

    fill_random();
    run_mm(5, 0, 0, 0, 0, 1);
    fill_const(2);
    run_mm(2, 0, 0, 0, 0, 0);
    check("pin_twos", exp_c[3][0], 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
